// File: rtl/mem_bus_responder_if.sv
// Bus bundle between the core's fetch/data initiators and the memory responder.
// Handshake: the master raises access with all request fields and holds them stable until it samples ack; ack is a one-cycle pulse from the slave.
`timescale 1ns/1ps
interface mem_bus_responder_if;
  logic [19:1] instr_addr;
  logic        instr_access;
  logic [15:0] instr_data;
  logic        instr_ack;
  logic [19:1] data_addr;
  logic [15:0] data_wr_data;
  logic        data_access;
  logic        data_wr_en;
  logic [1:0]  data_bytesel;
  logic        data_io;
  logic [15:0] data_rd_data;
  logic        data_ack;

  modport master (
    output instr_addr, instr_access, data_addr, data_wr_data, data_access,
           data_wr_en, data_bytesel, data_io,
    input  instr_data, instr_ack, data_rd_data, data_ack
  );

  modport slave (
    input  instr_addr, instr_access, data_addr, data_wr_data, data_access,
           data_wr_en, data_bytesel, data_io,
    output instr_data, instr_ack, data_rd_data, data_ack
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Two-initiator memory responder: round-robin arbitration onto one word RAM,
// programmable wait states, one-cycle ack per transfer.
`timescale 1ns/1ps
module mem_bus_responder #(
  parameter int addr_bits   = 12,
  parameter int wait_states = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_bus_responder_if.slave   bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  // grant / last_grant: 0 = instruction port, 1 = data port
  logic grant, grant_nxt;
  logic last_grant, last_grant_nxt;
  logic load;

  logic [addr_bits-1:0] lat_addr;
  logic                 lat_we;
  logic                 lat_io;
  logic [1:0]           lat_bs;
  logic [15:0]          lat_wd;

  logic [15:0] ram [0:(1<<addr_bits)-1];
  logic [15:0] ram_q;

  assign ram_q     = ram[lat_addr];
  assign dbg_state = state;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    load           = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.instr_access || bus.data_access) begin
          load = 1'b1;
          if (bus.instr_access && bus.data_access) grant_nxt = ~last_grant;
          else                                     grant_nxt = bus.data_access;
          last_grant_nxt = grant_nxt;
          cnt_nxt        = 4'(wait_states);
          state_nxt      = (wait_states == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = ACCESS;
      end
      ACCESS: state_nxt = RESP;
      RESP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= 4'd0;
      grant            <= 1'b0;
      last_grant       <= 1'b0;
      lat_addr         <= '0;
      lat_we           <= 1'b0;
      lat_io           <= 1'b0;
      lat_bs           <= 2'b00;
      lat_wd           <= 16'h0000;
      bus.instr_ack    <= 1'b0;
      bus.data_ack     <= 1'b0;
      bus.instr_data   <= 16'h0000;
      bus.data_rd_data <= 16'h0000;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      if (load) begin
        if (grant_nxt) begin
          lat_addr <= bus.data_addr[addr_bits:1];
          lat_we   <= bus.data_wr_en;
          lat_io   <= bus.data_io;
          lat_bs   <= bus.data_bytesel;
          lat_wd   <= bus.data_wr_data;
        end else begin
          lat_addr <= bus.instr_addr[addr_bits:1];
          lat_we   <= 1'b0;
          lat_io   <= 1'b0;
          lat_bs   <= 2'b00;
          lat_wd   <= 16'h0000;
        end
      end
      bus.instr_ack <= (state == ACCESS) && !grant;
      bus.data_ack  <= (state == ACCESS) && grant;
      // Read results land with the ack and hold until that port's next ack
      if (state == ACCESS) begin
        if (!grant)       bus.instr_data   <= ram_q;
        else if (!lat_we) bus.data_rd_data <= lat_io ? 16'hFFFF : ram_q;
      end
    end
  end

  // RAM is not reset; a transaction aborted by reset never reaches ACCESS
  always_ff @(posedge clk) begin
    if (state == ACCESS && lat_we && !lat_io) begin
      if (lat_bs[0]) ram[lat_addr][7:0]  <= lat_wd[7:0];
      if (lat_bs[1]) ram[lat_addr][15:8] <= lat_wd[15:8];
    end
  end

  if (addr_bits < 19) begin : g_alias
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.instr_addr[19:addr_bits+1], bus.data_addr[19:addr_bits+1]};
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: a wait_states=1 instance under random
// and directed traffic, plus a wait_states=0 instance for back-to-back fetches.
`timescale 1ns/1ps
module tb_mem_bus_responder;
  localparam int WS = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_responder_if bus1 ();
  mem_bus_responder_if bus0 ();
  logic [1:0] st1, st0;

  mem_bus_responder #(.addr_bits(12), .wait_states(WS)) dut (
    .clk(clk), .reset(reset), .bus(bus1.slave), .dbg_state(st1));
  mem_bus_responder #(.addr_bits(12), .wait_states(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .dbg_state(st0));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] mem_m [0:4095];
  bit          lg;              // last granted port, 1 = data
  logic [15:0] last_i, last_d;  // expected held output values
  logic [47:0] iq[$], dq[$], i0q[$];  // {ack cycle, data}
  logic [15:0] hold_i, hold_d, hold_i0;

  function automatic logic [18:0] raddr();
    logic [6:0] up;
    up = 7'($urandom);
    return {up, 6'd0, 6'($urandom_range(0, 63))};
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [47:0] e;
    if (!reset) begin
      if (bus1.instr_ack) begin
        if (iq.size() == 0) chk("instr_ack_unexpected", bus1.instr_ack, 0);
        else begin
          e = iq.pop_front();
          chk("instr_data", bus1.instr_data, e[15:0]);
          chk("instr_ack_cycle", cyc, e[47:16]);
          hold_i = e[15:0];
        end
      end else chk("instr_data_hold", bus1.instr_data, hold_i);
      if (bus1.data_ack) begin
        if (dq.size() == 0) chk("data_ack_unexpected", bus1.data_ack, 0);
        else begin
          e = dq.pop_front();
          chk("data_rd_data", bus1.data_rd_data, e[15:0]);
          chk("data_ack_cycle", cyc, e[47:16]);
          hold_d = e[15:0];
        end
      end else chk("data_rd_hold", bus1.data_rd_data, hold_d);
    end
  end

  always @(negedge clk) begin
    logic [47:0] e;
    if (!reset) begin
      if (bus0.instr_ack) begin
        if (i0q.size() == 0) chk("ws0_instr_ack_unexpected", bus0.instr_ack, 0);
        else begin
          e = i0q.pop_front();
          chk("ws0_instr_data", bus0.instr_data, e[15:0]);
          chk("ws0_instr_ack_cycle", cyc, e[47:16]);
          hold_i0 = e[15:0];
        end
      end else chk("ws0_instr_hold", bus0.instr_data, hold_i0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ack_i();
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus1.instr_ack && n < 60);
    chk("instr_ack_seen", bus1.instr_ack, 1);
    bus1.instr_access = 1'b0;
  endtask

  task automatic wait_ack_d();
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus1.data_ack && n < 60);
    chk("data_ack_seen", bus1.data_ack, 1);
    bus1.data_access = 1'b0;
  endtask

  // One transaction (or a simultaneous pair), expectations pushed at issue
  task automatic txn(input bit di, input logic [18:0] ia, input bit dd,
                     input logic [18:0] da, input logic [15:0] wd, input bit we,
                     input logic [1:0] bs, input bit io);
    int t, n, ac;
    bit order [2];
    @(posedge clk); #1;
    t = cyc;
    if (di && dd) begin order[0] = ~lg; order[1] = lg; n = 2; end
    else begin order[0] = dd; order[1] = 1'b0; n = 1; end
    for (int k = 0; k < n; k++) begin
      ac = t + 2 + WS + k * (WS + 3);
      if (order[k]) begin
        if (io) begin
          if (!we) last_d = 16'hFFFF;
        end else if (we) begin
          if (bs[0]) mem_m[da[11:0]][7:0]  = wd[7:0];
          if (bs[1]) mem_m[da[11:0]][15:8] = wd[15:8];
        end else last_d = mem_m[da[11:0]];
        dq.push_back({32'(ac), last_d});
      end else begin
        last_i = mem_m[ia[11:0]];
        iq.push_back({32'(ac), last_i});
      end
      lg = order[k];
    end
    bus1.instr_addr   = ia;
    bus1.data_addr    = da;
    bus1.data_wr_data = wd;
    bus1.data_wr_en   = we;
    bus1.data_bytesel = bs;
    bus1.data_io      = io;
    bus1.instr_access = di;
    bus1.data_access  = dd;
    fork
      if (di) wait_ack_i();
      if (dd) wait_ack_d();
    join
  endtask

  task automatic wr(input logic [18:0] a, input logic [15:0] v, input logic [1:0] bs);
    txn(0, 19'h0, 1, a, v, 1, bs, 0);
  endtask

  task automatic rd(input logic [18:0] a);
    txn(0, 19'h0, 1, a, 16'h0, 0, 2'b11, 0);
  endtask

  // Caller asserts reset away from a clock edge; checks reset values, clears the model
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_instr_ack", bus1.instr_ack, 0);
    chk("rst_data_ack", bus1.data_ack, 0);
    chk("rst_instr_data", bus1.instr_data, 0);
    chk("rst_data_rd_data", bus1.data_rd_data, 0);
    chk("rst_state_idle", st1, 0);
    chk("rst_ws0_state_idle", st0, 0);
    bus1.instr_access = 1'b0;
    bus1.data_access  = 1'b0;
    lg = 1'b0;
    last_i = 16'h0; last_d = 16'h0;
    hold_i = 16'h0; hold_d = 16'h0; hold_i0 = 16'h0;
    iq.delete(); dq.delete(); i0q.delete();
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  task automatic ws0_test();
    int t, n, acks;
    logic [15:0] v;
    v = 16'($urandom);
    @(posedge clk); #1;
    t = cyc;
    bus0.data_addr    = 19'h00040;
    bus0.data_wr_data = v;
    bus0.data_wr_en   = 1'b1;
    bus0.data_bytesel = 2'b11;
    bus0.data_io      = 1'b0;
    bus0.data_access  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus0.data_ack && n < 20);
    chk("ws0_data_ack_seen", bus0.data_ack, 1);
    chk("ws0_data_ack_cycle", cyc, t + 2);
    bus0.data_access = 1'b0;
    @(posedge clk); #1;
    t = cyc;
    for (int k = 0; k < 3; k++) i0q.push_back({32'(t + 2 + 3 * k), v});
    bus0.instr_addr   = 19'h7F040;
    bus0.instr_access = 1'b1;
    n = 0; acks = 0;
    do begin
      @(negedge clk); n++;
      if (bus0.instr_ack) acks++;
    end while (acks < 3 && n < 30);
    chk("ws0_instr_ack_count", acks, 3);
    bus0.instr_access = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus1.instr_addr = '0; bus1.instr_access = 1'b0; bus1.data_addr = '0;
    bus1.data_wr_data = '0; bus1.data_access = 1'b0; bus1.data_wr_en = 1'b0;
    bus1.data_bytesel = 2'b00; bus1.data_io = 1'b0;
    bus0.instr_addr = '0; bus0.instr_access = 1'b0; bus0.data_addr = '0;
    bus0.data_wr_data = '0; bus0.data_access = 1'b0; bus0.data_wr_en = 1'b0;
    bus0.data_bytesel = 2'b00; bus0.data_io = 1'b0;
    @(posedge clk); #2;
    do_reset();

    // Fill the address pool so every later read has known contents
    for (int i = 0; i < 64; i++) wr(19'(i), 16'($urandom), 2'b11);

    // Basic write/read and aliasing
    wr(19'h00010, 16'hBEEF, 2'b11);
    rd(19'h00010);
    rd(19'h01010);

    // Byte lanes
    wr(19'h00030, 16'h1234, 2'b11);
    wr(19'h00030, 16'hAB56, 2'b01);
    rd(19'h00030);
    wr(19'h00030, 16'hCD00, 2'b10);
    rd(19'h00030);
    wr(19'h00030, 16'hFFFF, 2'b00);
    rd(19'h00030);

    // I/O space
    txn(0, 19'h0, 1, raddr(), 16'h0, 0, 2'b11, 1);
    txn(0, 19'h0, 1, 19'h00010, 16'h0000, 1, 2'b11, 1);
    rd(19'h00010);

    // Contention right after reset, then back-to-back pairs alternate
    @(posedge clk); #2;
    do_reset();
    txn(1, 19'h00010, 1, 19'h00030, 16'h0, 0, 2'b11, 0);
    txn(1, 19'h00030, 1, 19'h00010, 16'h0, 0, 2'b11, 0);
    txn(1, 19'h00011, 1, 19'h00011, 16'h7777, 1, 2'b11, 0);

    // Reset in WAIT of a write: write must be dropped
    wr(19'h00020, 16'h5555, 2'b11);
    @(posedge clk); #1;
    bus1.data_addr = 19'h00020; bus1.data_wr_data = 16'hAAAA; bus1.data_wr_en = 1'b1;
    bus1.data_bytesel = 2'b11; bus1.data_io = 1'b0; bus1.data_access = 1'b1;
    @(posedge clk); #2;
    chk("mid_state_wait", st1, 1);
    do_reset();
    rd(19'h00020);

    // Randomised traffic
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: txn(1, raddr(), 0, 19'h0, 16'h0, 0, 2'b00, 0);
        1: txn(0, 19'h0, 1, raddr(), 16'($urandom), 1'($urandom), 2'($urandom), 0);
        2: txn(1, raddr(), 1, raddr(), 16'($urandom), 1'($urandom), 2'($urandom), 0);
        default: txn(1'($urandom), raddr(), 1, raddr(), 16'($urandom), 1'($urandom),
                     2'($urandom), 1);
      endcase
    end

    ws0_test();

    repeat (4) @(posedge clk);
    #1;
    chk("instr_queue_drained", iq.size(), 0);
    chk("data_queue_drained", dq.size(), 0);
    chk("ws0_queue_drained", i0q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the core's two bus initiators: the instruction fetch port (read-only) and the data port (read/write, byte-selectable, I/O flag).
- Arbitrates both ports onto one single-ported internal word RAM, inserts configurable wait states and returns a one-cycle ack.
- Sits directly on the core's instr_m_* and data_m_* / d_io pins in simulation and FPGA builds.

Parameters:
- addr_bits, 12: RAM depth is 2^addr_bits 16-bit words; word address = addr[addr_bits:1]; upper address bits ignored, so the RAM aliases.
- wait_states, 1: extra cycles between grant and ack; valid range 0..15.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- instr_addr  input  19  instruction word address [19:1]
- instr_access  input  1  instruction request, held until ack
- instr_data  output  16  instruction read data
- instr_ack  output  1  instruction transfer complete, one-cycle pulse
- data_addr  input  19  data word address [19:1]
- data_wr_data  input  16  data write value
- data_access  input  1  data request, held until ack
- data_wr_en  input  1  1 = write, 0 = read
- data_bytesel  input  2  bit0 = lane [7:0], bit1 = lane [15:8]
- data_io  input  1  I/O-space access flag
- data_rd_data  output  16  data read value
- data_ack  output  1  data transfer complete, one-cycle pulse

Behaviour:
- Reset values: instr_ack=0, data_ack=0, instr_data=0, data_rd_data=0, state=IDLE, wait counter=0, last_grant=INSTR. RAM contents are not reset.
- Handshake: the initiator holds access, addr, wr_en, bytesel, wr_data and io stable until it sees ack. Ack is high for exactly one cycle. access seen during the ack cycle is not a new request. A request is only recognised in IDLE.
- States:
  - IDLE: if no access, stay. Otherwise grant one port, latch its request fields, load wait counter = wait_states, go to WAIT (wait_states>0) or ACCESS (wait_states=0).
  - WAIT: decrement the counter; on reaching 1 go to ACCESS.
  - ACCESS: perform the RAM operation; assert the granted port's ack in the following cycle; go to RESP.
  - RESP: ack high for the granted port; return to IDLE.
- Latency: a request first seen in IDLE in cycle t gets ack in cycle t+2+wait_states. Minimum spacing between transactions is wait_states+3 cycles.
- Arbitration (both ports requesting in IDLE): round-robin. The port not in last_grant wins. last_grant updates on every grant. Right after reset, data wins the first contention. A sole requester is always granted.
- Reads:
  - Full 16-bit word returned regardless of bytesel.
  - instr_data / data_rd_data update only in the ack cycle and hold until that port's next ack.
- Writes:
  - The RAM lane is updated only if its bytesel bit is set; bytesel=00 still acks but changes nothing.
  - The write commits at the ACCESS-cycle edge. data_rd_data is unchanged by writes.
- I/O accesses (data_io=1):
  - The RAM is never touched. Same timing as a RAM access.
  - Reads return 16'hFFFF; writes are discarded.
- Instruction port is never a writer. Data writes to the word being fetched are serialised by arbitration: whichever port is granted first sees RAM state first.
- Asynchronous reset mid-transaction (WAIT/ACCESS/RESP):
  - Immediate return to IDLE with acks low.
  - A write not yet committed at the ACCESS edge is dropped.
  - The initiator must re-issue the request.
- Access dropped without ack: protocol violation. The responder completes the latched transaction anyway and acks; the ack is ignored by the initiator.

Test Plan:
- wait_states=1; data write addr=0x00010, data=0xBEEF, bytesel=11 -> data_ack one cycle at t+3. A later data read of 0x00010 returns 0xBEEF.
- Byte lanes: write 0x1234 with bytesel=11, then 0xAB56 with bytesel=01 -> read returns 0x1256. Then 0xCDxx with bytesel=10 -> read returns 0xCD56. A bytesel=00 write leaves 0xCD56.
- Contention: instr and data raise access in the same cycle after reset -> data acked first, instr acked wait_states+3 cycles later. Repeat both requests back-to-back -> grants alternate instr, data.
- I/O: data_io=1 read at any address -> data_rd_data=0xFFFF with normal latency. data_io=1 write of 0x0000 to 0x00010 -> RAM word unchanged.
- wait_states=0: instr read held continuously for 3 requests -> acks every 3rd cycle (t+2, t+5, t+8). instr_data stable between acks.
- Reset asserted in WAIT of a write to 0x00020 (old value 0x5555) -> acks low immediately, state IDLE. A subsequent read returns 0x5555. Aliasing: with addr_bits=12, addr 0x01010 reads the same word as 0x00010.
